// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, done pulse 6 cycles after the accepting edge.
// start is sampled only in IDLE and is dropped (not queued) while busy or done.
module seq_divider #(
  parameter int DIVIDEND_W = 6,
  parameter int DIVISOR_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int PR_W  = DIVISOR_W + 1;
  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]  pr_q, pr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [PR_W-1:0]       trial;
  logic                  ge;

  // The dividend register doubles as the quotient register: dividend bits
  // leave at the MSB while quotient bits enter at the LSB. pr stays below
  // the divisor, so it fits in DIVISOR_W bits between iterations.
  always_comb begin
    trial = {pr_q, dvd_q[DIVIDEND_W-1]};
    ge    = (trial >= {1'b0, dsr_q});

    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dsr_d = divisor;
          pr_d  = '0;
          cnt_d = CNT_W'(DIVIDEND_W - 1);
          quo_d = '0;
          rem_d = '0;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            quo_d   = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[DIVIDEND_W-2:0], ge};
        pr_d  = ge ? DIVISOR_W'(trial - {1'b0, dsr_q}) : DIVISOR_W'(trial);
        if (cnt_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = dvd_d;
          rem_d   = pr_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases, reset abort, ignored starts, exhaustive and random sweeps vs a / and % model.
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       div_by_zero;

  int    n_checks = 0;
  int    n_fail   = 0;
  string ctx      = "";

  seq_divider #(.DIVIDEND_W(6), .DIVISOR_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %0d expected %0d", tag, ctx, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after done.
  // poke_cyc > 0 raises a junk start in that cycle after the accept.
  task automatic do_div(input int a, input int b, input int poke_cyc);
    int busy_cnt;
    int done_at;
    int exp_q;
    int exp_r;
    ctx = $sformatf("%0d/%0d", a, b);
    exp_q = (b == 0) ? 63 : a / b;
    exp_r = (b == 0) ? 0  : a % b;
    dividend = 6'(a);
    divisor  = 3'(b);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 6'($urandom);
    divisor  = 3'($urandom);
    busy_cnt = 0;
    done_at  = -1;
    for (int cyc = 1; cyc <= 12 && done_at < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_at = cyc;
      if (cyc == poke_cyc) begin
        start    = 1'b1;
        dividend = 6'd10;
        divisor  = 3'd3;
      end
    end
    check_eq("done_latency", done_at, (b == 0) ? 1 : 7);
    check_eq("busy_cycles", busy_cnt, (b == 0) ? 0 : 6);
    check_eq("quotient", quotient, exp_q);
    check_eq("remainder", remainder, exp_r);
    check_eq("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
    @(negedge clk);
    start = 1'b0;
    check_eq("done_fall", done, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("hold_quotient", quotient, exp_q);
    check_eq("hold_remainder", remainder, exp_r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    ctx      = "reset";
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_quotient", quotient, 0);
    check_eq("rst_remainder", remainder, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_div(42, 5, 0);
    do_div(63, 7, 0);
    do_div(63, 1, 0);
    do_div(5, 7, 0);
    do_div(49, 0, 0);
    do_div(0, 3, 0);
    do_div(42, 5, 2);
    do_div(42, 5, 7);
    do_div(49, 0, 1);

    // Abort with reset three edges into a calculation.
    ctx      = "reset_abort";
    dividend = 6'd42;
    divisor  = 3'd5;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_quotient", quotient, 0);
    check_eq("abort_remainder", remainder, 0);
    check_eq("abort_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check_eq("abort_no_done", done_seen, 0);
    do_div(10, 3, 0);

    for (int a = 0; a < 64; a++)
      for (int b = 1; b < 8; b++)
        do_div(a, b, 0);

    for (int i = 0; i < 40; i++)
      do_div(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), int'($urandom_range(0, 8)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
